// File: rtl/alu_serial_ctrl.sv
// Bit-serial add/sub sequencer: drives one 1-bit ALU slice LSB..MSB, done WIDTH cycles after start.
// Flags built only with ALU_SERIAL_FLAGS_EN; start is ignored (not queued) while busy.
module alu_serial_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero,
  output logic             slice_a,
  output logic             slice_b,
  output logic             slice_b_inv,
  output logic             slice_c_in,
  output logic [1:0]       slice_operation,
  input  logic             slice_result,
  input  logic             slice_carry_out
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             sub_reg;
  logic [IDX_W-1:0] idx;
  logic             carry_q;
  logic             in_run;

  assign in_run          = (state == RUN);
  assign slice_a         = in_run & a_reg[idx];
  assign slice_b         = in_run & b_reg[idx];
  assign slice_c_in      = in_run & carry_q;
  assign slice_b_inv     = sub_reg;
  assign slice_operation = 2'b00;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      sub_reg   <= 1'b0;
      idx       <= '0;
      carry_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_reg   <= a;
            b_reg   <= b;
            sub_reg <= sub;
            idx     <= '0;
            carry_q <= sub;  // +1 of the two's-complement negate
            result  <= '0;
            busy    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          result[idx] <= slice_result;
          carry_q     <= slice_carry_out;
          if (idx == LAST) begin
            carry_out <= slice_carry_out;
            done      <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef ALU_SERIAL_FLAGS_EN
  // carry_q at the MSB edge is the carry into the MSB; the last result bit is still in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else if (state == IDLE && start) begin
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else if (in_run && idx == LAST) begin
      overflow <= carry_q ^ slice_carry_out;
      zero     <= ({slice_result, result[WIDTH-2:0]} == '0);
    end
  end
`else
  assign overflow = 1'b0;
  assign zero     = 1'b0;
`endif

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Randomized bench for alu_serial_ctrl (WIDTH=8) with a combinational slice and an arithmetic reference.
module tb_alu_serial_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         carry_out;
  logic         overflow;
  logic         zero;
  logic         slice_a;
  logic         slice_b;
  logic         slice_b_inv;
  logic         slice_c_in;
  logic [1:0]   slice_operation;
  logic         slice_result;
  logic         slice_carry_out;
  logic         slice_bb;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_serial_ctrl #(.WIDTH(W)) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .sub             (sub),
    .a               (a),
    .b               (b),
    .busy            (busy),
    .done            (done),
    .result          (result),
    .carry_out       (carry_out),
    .overflow        (overflow),
    .zero            (zero),
    .slice_a         (slice_a),
    .slice_b         (slice_b),
    .slice_b_inv     (slice_b_inv),
    .slice_c_in      (slice_c_in),
    .slice_operation (slice_operation),
    .slice_result    (slice_result),
    .slice_carry_out (slice_carry_out)
  );

  // 1-bit full-adder slice with optional B inversion
  assign slice_bb        = slice_b ^ slice_b_inv;
  assign slice_result    = slice_a ^ slice_bb ^ slice_c_in;
  assign slice_carry_out = (slice_a & slice_bb) | (slice_a & slice_c_in) | (slice_bb & slice_c_in);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // {carry, overflow, result} from unsigned/signed integer arithmetic
  function automatic logic [W+1:0] ref_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    int ux = int'(x);
    int uy = int'(y);
    int sx = int'($signed(x));
    int sy = int'($signed(y));
    int rs;
    logic [W-1:0] r;
    logic c;
    logic v;
    if (s) begin
      r  = W'(ux - uy);
      c  = (ux >= uy);
      rs = sx - sy;
    end else begin
      r  = W'(ux + uy);
      c  = (ux + uy) > 255;
      rs = sx + sy;
    end
    v = (rs > 127) || (rs < -128);
    return {c, v, r};
  endfunction

  // Called at #1 after the start edge; waits for done and checks the outcome.
  task automatic wait_done(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tsub, input bit scramble);
    int n = 0;
    bit seen = 0;
    logic [W+1:0] exp = ref_op(ta, tb, tsub);
    while (!seen && n < 20) begin
      check("slice_b_inv", 32'(slice_b_inv), 32'(tsub));
      check("slice_op", 32'(slice_operation), 32'd0);
      if (scramble) begin
        a   = W'($urandom);
        b   = W'($urandom);
        sub = 1'($urandom);
      end
      @(posedge clk); #1;
      n++;
      if (done) seen = 1;
    end
    check("latency", 32'(n), 32'(W));
    check("result", 32'(result), 32'(exp[W-1:0]));
    check("carry_out", 32'(carry_out), 32'(exp[W+1]));
`ifdef ALU_SERIAL_FLAGS_EN
    check("overflow", 32'(overflow), 32'(exp[W]));
    check("zero", 32'(zero), 32'(exp[W-1:0] == '0));
`else
    check("overflow", 32'(overflow), 32'd0);
    check("zero", 32'(zero), 32'd0);
`endif
    check("busy_in_done", 32'(busy), 32'd1);
    @(posedge clk); #1;
    check("done_pulse", 32'(done), 32'd0);
    check("busy_after", 32'(busy), 32'd0);
    check("result_hold", 32'(result), 32'(exp[W-1:0]));
  endtask

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tsub, input bit scramble);
    @(negedge clk);
    a = ta; b = tb; sub = tsub; start = 1'b1;
    @(posedge clk); #1;
    if (!scramble) start = 1'b0;
    wait_done(ta, tb, tsub, scramble);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic rs;
    bit saw;
    reset = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_slice", 32'({slice_a, slice_b, slice_b_inv, slice_c_in, slice_operation}), 32'd0);
    reset = 1'b0;

    run_op(8'h35, 8'h4A, 1'b0, 0);
    run_op(8'h10, 8'h10, 1'b1, 0);
    run_op(8'h7F, 8'h01, 1'b0, 0);
    run_op(8'h80, 8'h01, 1'b1, 0);

    // start held high with operands scrambled during RUN
    run_op(8'hC3, 8'h5A, 1'b1, 1);
    a = 8'h22; b = 8'h99; sub = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    check("restart_busy", 32'(busy), 32'd1);
    wait_done(8'h22, 8'h99, 1'b0, 0);

    // reset in the middle of RUN
    @(negedge clk);
    a = 8'hFF; b = 8'h01; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_result", 32'(result), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    saw = 0;
    repeat (12) begin
      @(posedge clk); #1;
      saw |= done;
    end
    check("no_done_after_rst", 32'(saw), 32'd0);
    run_op(8'h0F, 8'hF1, 1'b0, 0);

    for (int i = 0; i < 24; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rs = 1'($urandom);
      if (i % 6 == 0) rb = ra;
      run_op(ra, rb, rs, 0);
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(posedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
